// File: rtl/axi_wraddr_beat_expander.sv
// Expands one AXI3 write-address command into a stream of per-beat byte addresses,
// with FIXED/INCR/WRAP arithmetic and sticky protocol-violation flags.
module axi_wraddr_beat_expander #(
   parameter int ID_WIDTH      = 12,
   parameter int ADDRESS_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ID_WIDTH-1:0]      awid,
   input  logic [ADDRESS_WIDTH-1:0] awaddr,
   input  logic [3:0]               awlen,
   input  logic [2:0]               awsize,
   input  logic [1:0]               awburst,
   input  logic                     awvalid,
   output logic                     awready,
   output logic [ID_WIDTH-1:0]      beat_id,
   output logic [ADDRESS_WIDTH-1:0] beat_addr,
   output logic [3:0]               beat_num,
   output logic                     beat_last,
   output logic                     beat_valid,
   input  logic                     beat_ready,
   output logic                     busy,
   input  logic                     err_clear,
   output logic                     err_burst,
   output logic                     err_wrap,
   output logic                     err_4k
);

   typedef enum logic {IDLE, BURST} state_t;

   localparam logic [ADDRESS_WIDTH-1:0] ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

   state_t                   state;
   logic [3:0]               len;
   logic [2:0]               size;
   logic [1:0]               burst;
   logic                     aw_fire;
   logic                     beat_fire;
   logic [ADDRESS_WIDTH-1:0] size_bytes;
   logic [ADDRESS_WIDTH-1:0] size_mask;
   logic [ADDRESS_WIDTH-1:0] span_mask;
   logic [ADDRESS_WIDTH-1:0] next_addr;
   logic [ADDRESS_WIDTH-1:0] aw_size_mask;
   logic [11:0]              mask12;
   logic [13:0]              off4k;
   logic [13:0]              bytes4k;
   logic                     new_burst_err;
   logic                     new_wrap_err;
   logic                     new_4k_err;

   assign beat_valid = (state == BURST);
   assign busy       = beat_valid;
   assign beat_last  = beat_valid && (beat_num == len);
   assign beat_fire  = beat_valid & beat_ready;
   // Accepting during the final beat lets the next command follow without a bubble.
   assign awready    = reset & ((state == IDLE) | (beat_fire & beat_last));
   assign aw_fire    = awvalid & awready;

   always_comb begin
      size_bytes = ONE << size;
      size_mask  = size_bytes - ONE;
      span_mask  = ((ADDRESS_WIDTH'(len) + ONE) << size) - ONE;
      case (burst)
         2'd0:    next_addr = beat_addr;
         2'd2:    next_addr = (beat_addr & ~span_mask) | ((beat_addr + size_bytes) & span_mask);
         default: next_addr = (beat_addr & ~size_mask) + size_bytes;
      endcase
   end

   always_comb begin
      aw_size_mask  = (ONE << awsize) - ONE;
      mask12        = (12'd1 << awsize) - 12'd1;
      off4k         = {2'b00, awaddr[11:0] & ~mask12};
      bytes4k       = ({10'd0, awlen} + 14'd1) << awsize;
      new_burst_err = (awburst == 2'd3);
      new_wrap_err  = (awburst == 2'd2) &&
                      (!(awlen == 4'd1 || awlen == 4'd3 || awlen == 4'd7 || awlen == 4'd15) ||
                       ((awaddr & aw_size_mask) != '0));
      new_4k_err    = (awburst == 2'd1) && ((off4k + bytes4k) > 14'd4096);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         len       <= '0;
         size      <= '0;
         burst     <= '0;
         beat_id   <= '0;
         beat_addr <= '0;
         beat_num  <= '0;
         err_burst <= 1'b0;
         err_wrap  <= 1'b0;
         err_4k    <= 1'b0;
      end else begin
         // A new violation in the same cycle as err_clear keeps its flag set.
         err_burst <= (err_burst & ~err_clear) | (aw_fire & new_burst_err);
         err_wrap  <= (err_wrap  & ~err_clear) | (aw_fire & new_wrap_err);
         err_4k    <= (err_4k    & ~err_clear) | (aw_fire & new_4k_err);
         if (aw_fire) begin
            state     <= BURST;
            len       <= awlen;
            size      <= awsize;
            burst     <= awburst;
            beat_id   <= awid;
            beat_addr <= awaddr;
            beat_num  <= '0;
         end else if (beat_fire) begin
            if (beat_last) begin
               state <= IDLE;
            end else begin
               beat_num  <= beat_num + 4'd1;
               beat_addr <= next_addr;
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_wraddr_beat_expander.sv
// Directed-vector bench for axi_wraddr_beat_expander; expected addresses are hand-computed.
module tb_axi_wraddr_beat_expander;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] awid = '0;
   logic [31:0] awaddr = '0;
   logic [3:0]  awlen = '0;
   logic [2:0]  awsize = '0;
   logic [1:0]  awburst = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [11:0] beat_id;
   logic [31:0] beat_addr;
   logic [3:0]  beat_num;
   logic        beat_last;
   logic        beat_valid;
   logic        beat_ready = 1'b0;
   logic        busy;
   logic        err_clear = 1'b0;
   logic        err_burst;
   logic        err_wrap;
   logic        err_4k;

   int total = 0;
   int bad = 0;
   logic [31:0] ea [0:15];
   logic        pat [0:4];

   always #5 clk = ~clk;

   axi_wraddr_beat_expander #(.ID_WIDTH(12), .ADDRESS_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .beat_id(beat_id), .beat_addr(beat_addr), .beat_num(beat_num), .beat_last(beat_last),
      .beat_valid(beat_valid), .beat_ready(beat_ready), .busy(busy),
      .err_clear(err_clear), .err_burst(err_burst), .err_wrap(err_wrap), .err_4k(err_4k)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge with the DUT idle; returns just after the negedge following acceptance.
   task automatic do_aw(input logic [11:0] id, input logic [31:0] a, input logic [3:0] l,
                        input logic [2:0] s, input logic [1:0] b);
      awid = id; awaddr = a; awlen = l; awsize = s; awburst = b; awvalid = 1'b1;
      #1;
      chk("aw_ready_idle", awready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0;
      $display("aw id=%0h addr=%0h len=%0d size=%0d burst=%0d", id, a, l, s, b);
   endtask

   // Consumes n beats with beat_ready high, checking against ea[].
   task automatic run_beats(input int n, input logic [11:0] id);
      beat_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         #1;
         chk("beat_valid", beat_valid, 1'b1);
         chk("busy", busy, 1'b1);
         chk("beat_id", beat_id, id);
         chk("beat_addr", beat_addr, ea[i]);
         chk("beat_num", beat_num, 4'(i));
         chk("beat_last", beat_last, i == n - 1);
         chk("awready_beat", awready, i == n - 1);
         @(negedge clk);
      end
      #1;
      chk("idle_valid", beat_valid, 1'b0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", beat_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_last", beat_last, 1'b0);
      chk("rst_addr", beat_addr, 32'h0);
      chk("rst_num", beat_num, 4'h0);
      chk("rst_id", beat_id, 12'h0);
      chk("rst_awready", awready, 1'b0);
      chk("rst_errs", {err_burst, err_wrap, err_4k}, 3'b000);
      reset = 1'b1;
      #1;
      chk("post_rst_awready", awready, 1'b1);
      @(negedge clk);

      // INCR with unaligned start
      do_aw(12'h123, 32'h1003, 4'd3, 3'd2, 2'd1);
      ea[0] = 32'h1003; ea[1] = 32'h1004; ea[2] = 32'h1008; ea[3] = 32'h100C;
      run_beats(4, 12'h123);
      chk("incr_no_4k", err_4k, 1'b0);

      // WRAP legal
      do_aw(12'h0A1, 32'h38, 4'd7, 3'd3, 2'd2);
      ea[0] = 32'h38; ea[1] = 32'h00; ea[2] = 32'h08; ea[3] = 32'h10;
      ea[4] = 32'h18; ea[5] = 32'h20; ea[6] = 32'h28; ea[7] = 32'h30;
      chk("wrap_ok_err", err_wrap, 1'b0);
      run_beats(8, 12'h0A1);
      chk("wrap_ok_err_end", err_wrap, 1'b0);

      // WRAP with illegal length: flag set and held
      do_aw(12'h0A2, 32'h38, 4'd2, 3'd3, 2'd2);
      chk("wrap_bad_err", err_wrap, 1'b1);
      beat_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("wrap_bad_done", beat_valid, 1'b0);
      chk("wrap_err_held", err_wrap, 1'b1);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      chk("wrap_err_clr", err_wrap, 1'b0);

      // INCR ending exactly at the 4 KB boundary is legal
      do_aw(12'h010, 32'hFF0, 4'd1, 3'd3, 2'd1);
      chk("4k_edge_ok", err_4k, 1'b0);
      ea[0] = 32'hFF0; ea[1] = 32'hFF8;
      run_beats(2, 12'h010);

      // INCR crossing 4 KB
      do_aw(12'h011, 32'hFF8, 4'd1, 3'd3, 2'd1);
      chk("4k_err", err_4k, 1'b1);
      ea[0] = 32'hFF8; ea[1] = 32'h1000;
      run_beats(2, 12'h011);

      // Reserved burst type behaves as INCR
      do_aw(12'h012, 32'h101, 4'd2, 3'd2, 2'd3);
      chk("burst_err", err_burst, 1'b1);
      chk("4k_still", err_4k, 1'b1);
      ea[0] = 32'h101; ea[1] = 32'h104; ea[2] = 32'h108;
      run_beats(3, 12'h012);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      chk("errs_clr", {err_burst, err_wrap, err_4k}, 3'b000);

      // FIXED with backpressure: ready pattern 1,0,0,1,1
      beat_ready = 1'b0;
      do_aw(12'h020, 32'h200, 4'd2, 3'd2, 2'd0);
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
      begin
         int consumed = 0;
         for (int c = 0; c < 5; c++) begin
            beat_ready = pat[c];
            #1;
            chk("fix_valid", beat_valid, 1'b1);
            chk("fix_addr", beat_addr, 32'h200);
            chk("fix_num", beat_num, 4'(consumed));
            chk("fix_last", beat_last, consumed == 2);
            if (pat[c]) consumed++;
            @(negedge clk);
         end
      end
      #1;
      chk("fix_done", beat_valid, 1'b0);

      // Back-to-back: second command accepted during last beat of the first
      do_aw(12'h005, 32'h0, 4'd1, 3'd2, 2'd1);
      beat_ready = 1'b1;
      #1;
      chk("b2b_b0_addr", beat_addr, 32'h0);
      @(negedge clk);
      awid = 12'h009; awaddr = 32'h400; awlen = 4'd0; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
      #1;
      chk("b2b_b1_addr", beat_addr, 32'h4);
      chk("b2b_awready", awready, 1'b1);
      @(negedge clk);
      awvalid = 1'b0;
      #1;
      chk("b2b_valid", beat_valid, 1'b1);
      chk("b2b_id", beat_id, 12'h009);
      chk("b2b_addr", beat_addr, 32'h400);
      chk("b2b_num", beat_num, 4'd0);
      chk("b2b_last", beat_last, 1'b1);
      @(negedge clk);
      #1;
      chk("b2b_done", beat_valid, 1'b0);
      $display("aw id=9 addr=400 back-to-back");

      // Reset mid-burst
      do_aw(12'h033, 32'h0, 4'd3, 3'd2, 2'd1);
      beat_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("mid_num1", beat_num, 4'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", beat_valid, 1'b0);
      chk("mid_rst_awready", awready, 1'b0);
      chk("mid_rst_num", beat_num, 4'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rel_awready", awready, 1'b1);
      chk("mid_rel_valid", beat_valid, 1'b0);
      @(negedge clk);
      do_aw(12'h044, 32'h80, 4'd0, 3'd2, 2'd1);
      ea[0] = 32'h80;
      run_beats(1, 12'h044);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
